// File: rtl/mul_share_pkg.sv
// Shared width helpers for the shared-multiplier arbiter and its result FIFO.
package mul_share_pkg;

    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    function automatic int unsigned id_width(input int unsigned nreq);
        return (clog2_f(nreq) < 1) ? 1 : clog2_f(nreq);
    endfunction

    // Tag = {valid, requester id}
    function automatic int unsigned tag_width(input int unsigned idw);
        return 1 + idw;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return clog2_f(depth + 1);
    endfunction

    function automatic int unsigned inflight_width(input int unsigned lat);
        return clog2_f(lat + 1);
    endfunction

endpackage

// File: rtl/mul_share_fifo.sv
// Synchronous result FIFO with occupancy count; simultaneous read/write keeps count.
module mul_share_fifo
    import mul_share_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [DW-1:0]    wr_data,
    input  logic             rd_en,
    output logic [DW-1:0]    rd_data,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = clog2_f(DEPTH);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && !rd_en && count_q == CNT_W'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_en && count_q == '0));

endmodule

// File: rtl/multiplierCarry.sv
// Three-stage pipelined carry-save multiplier: operand regs, sum/carry regs, final add.
module multiplierCarry #(
    parameter int unsigned width = 4
) (
    input  logic                 clk,
    input  logic [width-1:0]     a,
    input  logic [width-1:0]     b,
    output logic [2*width-1:0]   y
);

    logic [width-1:0]   areg, breg;
    logic [2*width-1:0] psreg, pcreg, yi;
    logic [2*width-1:0] ps_d, pc_d, pp, ncar;

    // Bits carried past the MSB are multiples of 2^(2*width) and cannot affect the product.
    always_comb begin
        ps_d = '0;
        pc_d = '0;
        pp   = '0;
        ncar = '0;
        for (int unsigned i = 0; i < width; i++) begin
            pp   = breg[i] ? ({{width{1'b0}}, areg} << i) : '0;
            ncar = ((ps_d & pc_d) | (ps_d & pp) | (pc_d & pp)) << 1;
            ps_d = ps_d ^ pc_d ^ pp;
            pc_d = ncar;
        end
    end

    always_ff @(posedge clk) begin
        areg  <= a;
        breg  <= b;
        psreg <= ps_d;
        pcreg <= pc_d;
        yi    <= psreg + pcreg;
    end

    assign y = yi;

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin sharing of one non-stallable pipelined multiplier among NREQ requesters,
// with a credit-guarded result FIFO so no product is ever dropped.
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned NREQ       = 4,
    parameter int unsigned IDW        = 2,
    parameter int unsigned MUL_LAT    = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [2*WIDTH-1:0]      resp_y,
    output logic [IDW-1:0]          resp_id,
    output logic                    busy
);

    localparam int unsigned TAG_W = tag_width(IDW);
    localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);
    localparam int unsigned INF_W = inflight_width(MUL_LAT);
    localparam int unsigned SUM_W = clog2_f(FIFO_DEPTH + MUL_LAT + 1);
    localparam int unsigned FW    = 2*WIDTH + IDW;

    logic [IDW-1:0]     rr_q, rr_d, gnt_idx;
    logic [IDW:0]       cand;
    logic               gnt_found, can_issue, accept;
    logic [WIDTH-1:0]   mul_a, mul_b;
    logic [2*WIDTH-1:0] mul_y;
    logic [TAG_W-1:0]   tag_q [MUL_LAT];
    logic [TAG_W-1:0]   tag_d [MUL_LAT];
    logic [INF_W-1:0]   inflight_q, inflight_d;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_wr, fifo_rd;
    logic [FW-1:0]      fifo_wdata, fifo_rdata;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
            if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDW-1:0];
            end
        end
    end

    // Credits only see the FIFO count after the edge, so resp_ready never reaches req_ready.
    assign can_issue = rst_n &&
        ((SUM_W'(inflight_q) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH));
    assign accept = gnt_found & can_issue;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[gnt_idx] = 1'b1;
        mul_a = accept ? req_a[gnt_idx*WIDTH +: WIDTH] : '0;
        mul_b = accept ? req_b[gnt_idx*WIDTH +: WIDTH] : '0;
        if (accept) rr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
        else        rr_d = rr_q;
    end

    // One tag stage per multiplier stage so the exiting tag lines up with y.
    always_comb begin
        tag_d[0] = {accept, accept ? gnt_idx : '0};
        for (int unsigned i = 1; i < MUL_LAT; i++) tag_d[i] = tag_q[i-1];
    end

    assign fifo_wr    = tag_q[MUL_LAT-1][TAG_W-1];
    assign fifo_wdata = {mul_y, tag_q[MUL_LAT-1][IDW-1:0]};

    always_comb begin
        case ({accept, fifo_wr})
            2'b10:   inflight_d = inflight_q + INF_W'(1);
            2'b01:   inflight_d = inflight_q - INF_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= '0;
            inflight_q <= '0;
            for (int unsigned i = 0; i < MUL_LAT; i++) tag_q[i] <= '0;
        end else begin
            rr_q       <= rr_d;
            inflight_q <= inflight_d;
            for (int unsigned i = 0; i < MUL_LAT; i++) tag_q[i] <= tag_d[i];
        end
    end

    multiplierCarry #(.width(WIDTH)) u_mul (
        .clk (clk),
        .a   (mul_a),
        .b   (mul_b),
        .y   (mul_y)
    );

    mul_share_fifo #(.DW(FW), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .count   (fifo_count)
    );

    assign resp_valid = (fifo_count != '0);
    assign fifo_rd    = resp_valid & resp_ready;
    assign resp_y     = resp_valid ? fifo_rdata[FW-1:IDW] : '0;
    assign resp_id    = resp_valid ? fifo_rdata[IDW-1:0] : '0;
    assign busy       = (inflight_q != '0) | (fifo_count != '0);

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb: arbitration order, latency, credits and reset.
module tb_mul_share_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a, req_b;
    logic        resp_valid, resp_ready;
    logic [7:0]  resp_y;
    logic [1:0]  resp_id;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mul_share_arb #(
        .WIDTH(4), .NREQ(4), .IDW(2), .MUL_LAT(3), .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_y     (resp_y),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 4'hF; resp_ready = 1'b0;
        req_a = 16'h0; req_b = 16'h0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        n_checks++; if (resp_y !== 8'd0) begin n_fail++; $display("FAIL reset_resp_y: got %0d expected 0", resp_y); end
        n_checks++; if (resp_id !== 2'd0) begin n_fail++; $display("FAIL reset_resp_id: got %0d expected 0", resp_id); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        req_valid = 4'h0;
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_release: got valid=%b busy=%b expected 0 0", resp_valid, busy); end
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid = 4'b0100; req_a = 16'h0300; req_b = 16'h0500; resp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            case (c)
                0: begin
                    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b expected 0100", req_ready); end
                end
                1: begin
                    req_valid = 4'b0000;
                    n_checks++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL single_inflight: got busy=%b valid=%b expected 1 0", busy, resp_valid); end
                end
                2, 3: begin
                    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid c%0d: got %b expected 0", c, resp_valid); end
                end
                4: begin
                    n_checks++; if (resp_valid !== 1'b1 || resp_y !== 8'd15 || resp_id !== 2'd2) begin n_fail++; $display("FAIL single_result: got valid=%b y=%0d id=%0d expected 1 15 2", resp_valid, resp_y, resp_id); end
                end
                default: begin
                    n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_done: got valid=%b busy=%b expected 0 0", resp_valid, busy); end
                end
            endcase
            @(negedge clk);
        end
    endtask

    // Every accept takes a credit until its result is popped, so with depth 4 and
    // latency 3 the grant stream runs four on, one off.
    task automatic test_round_robin();
        logic [3:0] exp_gnt [10];
        logic [1:0] exp_id  [8];
        logic [7:0] prod    [4];
        int got;
        exp_gnt = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0000,
                    4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0000};
        exp_id  = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        prod    = '{8'd30, 8'd63, 8'd22, 8'd39};
        got = 0;
        @(negedge clk);
        req_valid = 4'hF; req_a = 16'hDB75; req_b = 16'h3296; resp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (resp_valid) begin
                n_checks++;
                if (got >= 8) begin n_fail++; $display("FAIL rr_extra_resp: got id=%0d y=%0d expected none", resp_id, resp_y); end
                else if (resp_id !== exp_id[got] || resp_y !== prod[exp_id[got]]) begin
                    n_fail++; $display("FAIL rr_resp%0d: got id=%0d y=%0d expected id=%0d y=%0d", got, resp_id, resp_y, exp_id[got], prod[exp_id[got]]);
                end
                got++;
            end
            if (c < 10) begin
                n_checks++; if (req_ready !== exp_gnt[c]) begin n_fail++; $display("FAIL rr_grant c%0d: got %b expected %b", c, req_ready, exp_gnt[c]); end
            end else begin
                req_valid = 4'h0;
            end
            @(negedge clk);
        end
        n_checks++; if (got != 8) begin n_fail++; $display("FAIL rr_resp_count: got %0d expected 8", got); end
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_fill  [10];
        logic [3:0] exp_drain [8];
        logic [1:0] exp_id    [10];
        logic [7:0] prod      [4];
        int got;
        exp_fill  = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0000,
                      4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        exp_drain = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b1000, 4'b0001};
        exp_id    = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        prod      = '{8'd30, 8'd63, 8'd22, 8'd39};
        got = 0;
        @(negedge clk);
        req_valid = 4'hF; req_a = 16'hDB75; req_b = 16'h3296; resp_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_checks++; if (req_ready !== exp_fill[c]) begin n_fail++; $display("FAIL bp_fill_grant c%0d: got %b expected %b", c, req_ready, exp_fill[c]); end
            if (c >= 4) begin
                n_checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_y !== 8'd39) begin n_fail++; $display("FAIL bp_head_hold c%0d: got valid=%b id=%0d y=%0d expected 1 3 39", c, resp_valid, resp_id, resp_y); end
            end
            if (c == 9) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_full_busy: got %b expected 1", busy); end
            end
            @(negedge clk);
        end
        for (int s = 0; s < 20; s++) begin
            #1;
            if (s == 0) resp_ready = 1'b1;
            if (resp_valid) begin
                n_checks++;
                if (got >= 10) begin n_fail++; $display("FAIL bp_extra_resp: got id=%0d y=%0d expected none", resp_id, resp_y); end
                else if (resp_id !== exp_id[got] || resp_y !== prod[exp_id[got]]) begin
                    n_fail++; $display("FAIL bp_resp%0d: got id=%0d y=%0d expected id=%0d y=%0d", got, resp_id, resp_y, exp_id[got], prod[exp_id[got]]);
                end
                got++;
            end
            if (s < 8) begin
                n_checks++; if (req_ready !== exp_drain[s]) begin n_fail++; $display("FAIL bp_drain_grant s%0d: got %b expected %b", s, req_ready, exp_drain[s]); end
            end else begin
                req_valid = 4'h0;
            end
            @(negedge clk);
        end
        n_checks++; if (got != 10) begin n_fail++; $display("FAIL bp_resp_count: got %0d expected 10", got); end
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_corners();
        logic [3:0] exp_gnt [4];
        logic [1:0] exp_id  [4];
        logic [7:0] exp_y   [4];
        int got;
        exp_gnt = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_id  = '{2'd1, 2'd2, 2'd3, 2'd0};
        exp_y   = '{8'd0, 8'd15, 8'd64, 8'd225};
        got = 0;
        @(negedge clk);
        req_valid = 4'hF; req_a = 16'h810F; req_b = 16'h8F9F; resp_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (resp_valid) begin
                n_checks++;
                if (got >= 4) begin n_fail++; $display("FAIL corner_extra_resp: got id=%0d y=%0d expected none", resp_id, resp_y); end
                else if (resp_id !== exp_id[got] || resp_y !== exp_y[got]) begin
                    n_fail++; $display("FAIL corner_resp%0d: got id=%0d y=%0d expected id=%0d y=%0d", got, resp_id, resp_y, exp_id[got], exp_y[got]);
                end
                got++;
            end
            if (c < 4) begin
                n_checks++; if (req_ready !== exp_gnt[c]) begin n_fail++; $display("FAIL corner_grant c%0d: got %b expected %b", c, req_ready, exp_gnt[c]); end
            end else begin
                req_valid = 4'h0;
            end
            @(negedge clk);
        end
        n_checks++; if (got != 4) begin n_fail++; $display("FAIL corner_resp_count: got %0d expected 4", got); end
    endtask

    task automatic test_reset_midop();
        int found;
        @(negedge clk);
        req_valid = 4'b0001; req_a = 16'h0005; req_b = 16'h0005; resp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (c < 3) begin
                n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midop_grant c%0d: got %b expected 0001", c, req_ready); end
            end else if (c == 3) begin
                req_valid = 4'h0;
            end else begin
                n_checks++; if (resp_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL midop_loaded: got valid=%b busy=%b expected 1 1", resp_valid, busy); end
            end
            if (c < 4) @(negedge clk);
        end
        #1;
        rst_n = 1'b0; req_valid = 4'b0001;
        #1;
        n_checks++; if (resp_valid !== 1'b0 || resp_y !== 8'd0 || resp_id !== 2'd0) begin n_fail++; $display("FAIL midop_async_resp: got valid=%b y=%0d id=%0d expected 0 0 0", resp_valid, resp_y, resp_id); end
        n_checks++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL midop_async_ctrl: got busy=%b ready=%b expected 0 0000", busy, req_ready); end
        @(negedge clk); #1;
        rst_n = 1'b1; req_valid = 4'h0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL midop_stale_resp c%0d: got %b expected 0", c, resp_valid); end
        end
        req_valid = 4'b1001; req_a = 16'h9002; req_b = 16'h9007; resp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midop_rr_restart: got %b expected 0001", req_ready); end
        found = -1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk); #1;
            if (c == 0) req_valid = 4'h0;
            if (resp_valid && found < 0) begin
                found = c;
                n_checks++; if (resp_y !== 8'd14 || resp_id !== 2'd0) begin n_fail++; $display("FAIL midop_new_result: got y=%0d id=%0d expected 14 0", resp_y, resp_id); end
            end
        end
        n_checks++; if (found != 3) begin n_fail++; $display("FAIL midop_new_latency: got %0d expected 3", found); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_corners();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
